// File: rtl/siso_ctrl_pkg.sv
// Shared types and constants for the serial shift controller slice.
package siso_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic SOUT_IDLE = 1'b0;

endpackage

// File: rtl/siso_shift_controller_if.sv
// Parallel word handshake between producer and serial shift controller.
interface siso_shift_controller_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/siso_shift_core.sv
// Serial-in/serial-out shift core: loads a word, emits it LSB-first on enable.
module siso_shift_core
  import siso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      sout <= SOUT_IDLE;
    end else if (load) begin
      sreg <= load_data;
    end else if (enable) begin
      sout <= sreg[0];
      sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/siso_shift_controller.sv
// Frame sequencer: accepts a word, paces it out LSB-first via a divider,
// and flags normal completion with a one-cycle done pulse.
module siso_shift_controller
  import siso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      div,
  siso_shift_controller_if.slave hs,
  input  logic                  abort,
  output logic                  sout,
  output logic                  shift_en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [BCW-1:0]   bit_cnt;

  logic accept_c;
  logic tick_c;
  logic last_c;
  logic core_en_c;
  logic core_clr_c;

  assign hs.in_ready = (state == IDLE) && !reset;
  assign accept_c    = hs.in_valid && hs.in_ready;
  assign tick_c      = (state == SHIFT) && (div_cnt == div_q);
  assign last_c      = (bit_cnt == BCW'(WIDTH));

  // The tick after the final bit closes the frame instead of shifting.
  assign core_en_c  = tick_c && !abort && !last_c;
  assign core_clr_c = reset || ((state == SHIFT) && (abort || (tick_c && last_c)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_q    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift_en <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            state   <= SHIFT;
            div_q   <= div;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else if (tick_c) begin
            div_cnt <= '0;
            if (last_c) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_cnt <= '0;
            end else begin
              shift_en <= 1'b1;
              bit_cnt  <= bit_cnt + BCW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  siso_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (core_clr_c),
    .load     (accept_c),
    .load_data(hs.in_data),
    .enable   (core_en_c),
    .sout     (sout)
  );

endmodule

// File: doc/siso_shift_controller.md
Name: siso_shift_controller

Overview:
- Sequencer that accepts a parallel word over a valid/ready handshake and streams it LSB-first through an internal serial-in/serial-out style shift core.
- Generates the shift-enable cadence from a programmable clock divider and reports frame completion.
- Sits between a parallel producer and a single-bit serial consumer in the registers/serial datapath area.

Parameters:
- WIDTH, 8, bits per frame (must be 2 or more).
- DIV_W, 8, width of the divider setting.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- div  in  DIV_W  bit period minus 1, in clk cycles; sampled at accept.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to serialise.
- abort  in  1  synchronous frame abort.
- sout  out  1  serial output, registered.
- shift_en  out  1  registered one-cycle pulse, coincident with each sout update.
- busy  out  1  frame in progress.
- done  out  1  registered one-cycle pulse at normal frame end.

Behaviour:
- Reset (clk = clk, reset = reset: synchronous, active-high), effective at the next edge:
  - state IDLE
  - sout = 0, shift_en = 0, done = 0, busy = 0
  - shift core, bit counter and divider counter all 0
- in_ready is combinational and equals (state == IDLE && !reset).
- States:
  - IDLE -> SHIFT on in_valid && in_ready.
  - SHIFT -> IDLE on frame end or abort.
- Accept edge E0:
  - Load in_data into the shift core.
  - Latch div into div_q.
  - Clear the divider counter and the bit counter.
  - busy = 1 from E0.
- Tick:
  - In SHIFT, tick = (div_cnt == div_q).
  - On a tick, div_cnt goes to 0; otherwise it increments.
  - div_q = 0 gives a tick every cycle.
- Bit output:
  - Bit k (k = 0..WIDTH-1) is driven on sout at edge E0 + (k+1)(div_q+1).
  - shift_en is high for the cycle following each such edge.
  - On each of these ticks the shift core shifts right by 1 and the bit counter increments.
- Frame end:
  - The tick at E0 + (WIDTH+1)(div_q+1) ends the last bit period.
  - At that edge: sout = 0, shift_en = 0, done = 1 for one cycle, busy = 0, state IDLE.
  - in_ready is high in the done cycle, so back-to-back frames have no idle gap beyond that cycle.
- Abort:
  - Abort asserted in SHIFT forces IDLE at the next edge.
  - sout = 0, no done pulse, busy = 0.
  - Abort wins over a coincident tick.
  - Abort in IDLE is ignored; abort together with an accept in IDLE still accepts.
- in_valid while busy: not accepted. in_data must be held stable by the producer until accepted.
- div changes mid-frame have no effect.
- Reset mid-frame behaves like abort, and additionally clears all state.
- Width rules:
  - Bit counter is clog2(WIDTH+1) bits.
  - Divider counter is DIV_W bits.
  - No wrap-around is possible because div_cnt never exceeds div_q.

Decomposition:
- Shared package siso_ctrl_pkg holds:
  - State enum (IDLE, SHIFT).
  - Localparam for the sout idle level (0).
- One sub-module, siso_shift_core (WIDTH):
  - Inputs: clk, reset, load, load_data, enable.
  - Output: registered sout.
  - On enable: sout <= reg[0] and reg shifts right by 1.
- The controller owns the FSM, divider, bit counter, handshake and done/abort logic.

Test Plan:
- WIDTH=8, div=0, in_data=0xA5 accepted at E0 -> sout = 1,0,1,0,0,1,0,1 at E1..E8; shift_en high in 8 cycles; done pulse at E9; busy high E0..E9.
- div=2, in_data=0x01 -> sout=1 at E3, then 0 at E6, E9, ..., E24; shift_en pulses every 3 cycles; done at E27.
- in_valid held high with words 0x3C then 0xC3, div=0 -> second word accepted in the done cycle of the first; no extra gap; both bit streams correct.
- Abort asserted two cycles after bit 3 appears, coincident with a tick -> IDLE next edge; sout=0; no done pulse; in_ready=1; next frame 0xFF streams correctly.
- Reset asserted mid-frame (div=1) -> next edge: sout, shift_en, done, busy all 0; in_ready=1 after reset deasserts; div changed mid-frame has no effect on the current frame.
- in_valid high while busy with in_data changing, and abort pulsed in IDLE -> no extra accepts; abort in IDLE has no effect; only the first word is transmitted.
